piso_frame_tx: RTL
==================

// Module: piso_frame_tx
// PURPOSE
//  Parallel-in/serial-out frame transmitter: accepts a WIDTH-bit word over a valid/ready
//  handshake and drives it one bit per shift strobe onto a complementary serial pair q/notq.
//  It is the transmit end of the serial bit line sampled by our D flip-flop capture stages.
//  Frame = start(0), WIDTH data bits, [parity], stop(1); the line idles high.
// PARAMETERS
//  WIDTH      8  data bits per frame (2..32)
//  MSB_FIRST  0  1: data shifted MSB first; 0: LSB first
// PORTS
//  clk        in   1      rising-edge clock, the only clock
//  clr_n      in   1      synchronous reset, active-low; sampled on rising clk
//  shift_en   in   1      bit-time strobe; one serial bit advances per clk with shift_en=1
//  load_valid in   1      word offered on load_data
//  load_ready out  1      transmitter can accept a word this cycle
//  load_data  in   WIDTH  word to transmit; captured when load_valid & load_ready
//  q          out  1      serial line, registered
//  notq       out  1      always ~q, registered in the same cycle as q
//  busy       out  1      frame in progress (state != IDLE)
//  done       out  1      one-clk pulse in the cycle the stop bit ends
// BEHAVIOUR
//  - Reset (clr_n=0 at rising clk): state=IDLE, q=1, notq=0, load_ready=0 for that cycle then 1,
//    busy=0, done=0, bit counter=0, shift register=0. Reset mid-frame aborts it; no done pulse.
//  - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: q=1, load_ready=1. Handshake (load_valid & load_ready) at edge N: word latched,
//    state=START, load_ready=0 from edge N. q unchanged until next shift_en.
//  - START: on shift_en, q<=0 (start bit begins), state=DATA, count=0.
//  - DATA: on each shift_en, q<=current data bit (LSB or MSB per MSB_FIRST), count++;
//    after the WIDTH-th bit is driven, next shift_en goes to PARITY (or STOP if no parity).
//  - STOP: on shift_en, q<=1; the following shift_en ends stop bit: done=1 for one clk,
//    state=IDLE, load_ready=1 the same edge.
//  - Each bit lasts exactly one shift_en period; shift_en=0 holds q, state, counter.
//  - shift_en in the same cycle as the handshake is ignored for frame timing (start bit
//    begins on the next strobe). load_valid while busy is ignored; load_data need not hold.
//  - Back-to-back: handshake in the done cycle is legal; next frame's start bit on next strobe.
//  - notq==~q in every cycle including reset. Counter width = $clog2(WIDTH+1); never wraps.
// CONFIGURATION
//  PIFT_PARITY_EN defined: PARITY state inserted after DATA; q<=even parity (XOR of the
//    WIDTH data bits) for one bit time. Frame = WIDTH+3 bit times.
//  Undefined: no PARITY state, DATA -> STOP directly; frame = WIDTH+2 bit times.
// STRUCTURE
//  - Shared package piso_pkg: state encoding (IDLE/START/DATA/PARITY/STOP localparams),
//    IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
//  - One sub-module: piso_shreg (WIDTH-bit load/shift register with MSB_FIRST select);
//    FSM, counter, parity and q/notq registers live in piso_frame_tx.
// TESTING
//  1 Reset: clr_n=0 two clks mid-frame -> q=1, notq=0, busy=0, done=0, load_ready=1 after release.
//  2 WIDTH=8, LSB first, shift_en every clk, load 8'hA5 -> q: 0,1,0,1,0,0,1,0,1,1; done after 10th bit.
//  3 MSB_FIRST=1, load 8'h81, shift_en every 4th clk -> q: 0,1,0,0,0,0,0,0,1,1, each bit 4 clks wide.
//  4 PIFT_PARITY_EN, load 8'h07 -> parity bit 1 after data; 8'h03 -> parity 0; frame 11 bits.
//  5 load_valid held high with words 8'h11,8'h22 -> second accepted in done cycle; no idle bit gap.
//  6 shift_en=0 for 20 clks mid-DATA -> q, notq, counter frozen; frame resumes unchanged.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO frame transmitter: FSM state encoding and line levels.
package piso_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/piso_shreg.sv
// WIDTH-bit load/shift register; bit_out always presents the next data bit to transmit.
module piso_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             bit_out
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift) begin
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_out = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_frame_tx.sv
// Serial frame transmitter: start(0), WIDTH data bits, optional even parity, stop(1).
// Define PIFT_PARITY_EN to insert the parity bit between data and stop.
module piso_frame_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             shift_en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             q,
  output logic             notq,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;
  logic          notq_q, notq_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          accept;
  logic          shift_bit;
  logic          data_bit;

`ifdef PIFT_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (accept) begin
      par_d = ^load_data;
    end
  end
`endif

  assign accept = load_valid & ready_q;

  piso_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (accept),
    .load_data(load_data),
    .shift    (shift_bit),
    .bit_out  (data_bit)
  );

  // Transitions happen only on strobes; the stop bit is driven on the strobe that leaves DATA/PARITY.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    done_d    = 1'b0;
    shift_bit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (shift_en) begin
          q_d     = START_LEVEL;
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (shift_en) begin
          if (cnt_q != LAST_CNT) begin
            q_d       = data_bit;
            shift_bit = 1'b1;
            cnt_d     = cnt_q + 1'b1;
          end else begin
`ifdef PIFT_PARITY_EN
            q_d     = par_q;
            state_d = ST_PARITY;
`else
            q_d     = IDLE_LEVEL;
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef PIFT_PARITY_EN
      ST_PARITY: begin
        if (shift_en) begin
          q_d     = IDLE_LEVEL;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (shift_en) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    notq_d  = ~q_d;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_q     <= IDLE_LEVEL;
      notq_q  <= ~IDLE_LEVEL;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef PIFT_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      notq_q  <= notq_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef PIFT_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign q          = q_q;
  assign notq       = notq_q;
  assign done       = done_q;
  assign load_ready = ready_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
